muldiv_ctrl: RTL

//   Multi-cycle sequencer for MULT/MULTU/DIV/DIVU, and owner of the HI/LO register pair.

---
 rtl/muldiv_ctrl_pkg.sv | 19 +
 rtl/muldiv_ctrl_div_radix2_step.sv | 22 ++
 rtl/muldiv_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      ALU_MULT = 2'd0,
      ALU_DIV  = 2'd1
   } mult_op_enum;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_MUL,
      MD_DIV,
      MD_DONE
   } muldiv_state_enum;

   // Quotient reported for a zero divisor; sliced to the operand width at use.
   localparam logic [63:0] MD_DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_ctrl_div_radix2_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and retire one quotient bit.
module div_radix2_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quot,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quot_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem < divisor always holds, so diff[WIDTH] is a clean borrow flag.
   assign shifted   = {rem, quot[WIDTH-1]};
   assign diff      = shifted - {1'b0, divisor};
   assign rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quot_next = {quot[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO pair;
// stalls EX through busy_o and services MTHI/MTLO when idle.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic             sign_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   input  logic             cancel_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CW    = $clog2(STEPS + 1);

   muldiv_state_enum state, state_next;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_mul;
   logic [2*WIDTH-1:0] acc_div;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   opnd_b;
   logic [WIDTH-1:0]   hi, lo;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   quot_res, rem_res;
   logic [CW-1:0]      count;
   logic               neg_q, neg_r;
   logic               accept, last, div_zero;

   assign accept   = start_i && !cancel_i && (state == MD_IDLE || state == MD_DONE);
   assign div_zero = (op_i == ALU_DIV) && (src_b_i == '0);
   assign last     = (count == CW'(STEPS - 1));
   assign mag_a    = (sign_i && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
   assign mag_b    = (sign_i && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         MD_IDLE, MD_DONE: begin
            if (accept) begin
               if (div_zero)              state_next = MD_DONE;
               else if (op_i == ALU_DIV)  state_next = MD_DIV;
               else                       state_next = MD_MUL;
            end else begin
               state_next = MD_IDLE;
            end
         end
         MD_MUL, MD_DIV: if (last) state_next = MD_DONE;
         default:        state_next = MD_IDLE;
      endcase
      if (cancel_i) state_next = MD_IDLE;
   end

   assign busy_o = (state == MD_MUL) || (state == MD_DIV);
   assign done_o = (state == MD_DONE);

   // Shift-add: the multiplier sits in the low half of acc and is consumed LSB first.
   always_comb begin
      logic [WIDTH:0] sum;
      sum     = '0;
      acc_mul = acc;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         sum     = {1'b0, acc_mul[2*WIDTH-1:WIDTH]} + (acc_mul[0] ? {1'b0, opnd_b} : '0);
         acc_mul = {sum, acc_mul[WIDTH-1:1]};
      end
   end

   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : step
      logic [WIDTH-1:0] rem_in, quot_in, rem_out, quot_out;
      if (g == 0) begin : first
         assign rem_in  = acc[2*WIDTH-1:WIDTH];
         assign quot_in = acc[WIDTH-1:0];
      end else begin : chain
         assign rem_in  = step[g-1].rem_out;
         assign quot_in = step[g-1].quot_out;
      end
      div_radix2_step #(.WIDTH(WIDTH)) u_step (
         .rem       (rem_in),
         .quot      (quot_in),
         .divisor   (opnd_b),
         .rem_next  (rem_out),
         .quot_next (quot_out)
      );
   end

   assign acc_div  = {step[BITS_PER_CYCLE-1].rem_out, step[BITS_PER_CYCLE-1].quot_out};
   assign mul_res  = neg_q ? -acc_mul : acc_mul;
   assign quot_res = neg_q ? -acc_div[WIDTH-1:0] : acc_div[WIDTH-1:0];
   assign rem_res  = neg_r ? -acc_div[2*WIDTH-1:WIDTH] : acc_div[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         opnd_b <= '0;
         count  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else if (cancel_i) begin
         // abandon the op: HI/LO and operand state are left as they are
      end else if (accept) begin
         acc    <= {{WIDTH{1'b0}}, mag_a};
         opnd_b <= mag_b;
         count  <= '0;
         neg_q  <= sign_i && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
         neg_r  <= sign_i && src_a_i[WIDTH-1];
         if (div_zero) begin
            hi <= src_a_i;
            lo <= MD_DIV0_QUOT[WIDTH-1:0];
         end
      end else if (state == MD_MUL) begin
         acc   <= acc_mul;
         count <= count + CW'(1);
         if (last) begin
            hi <= mul_res[2*WIDTH-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
         end
      end else if (state == MD_DIV) begin
         acc   <= acc_div;
         count <= count + CW'(1);
         if (last) begin
            hi <= rem_res;
            lo <= quot_res;
         end
      end else begin
         if (mthi_i) hi <= wdata_i;
         if (mtlo_i) lo <= wdata_i;
      end
   end

   assign hi_o = hi;
   assign lo_o = lo;

endmodule
